stage_two_execute: RTL and testbench
====================================

Name: stage_two_execute

Overview:
Execute stage. It is the consuming end of the stage-one pipeline register bundle: it takes the flopped ALU operands, ALU control, write-enables and instruction tag from stage one, and computes the result. ADD/SUB/AND/OR/SLL/SRL complete in one cycle. MUL and DIV run as iterative 16-step state machines. While a MUL/DIV is running, the block asserts stall back to stage one and to the PC register. The registered result bundle goes to stage three (memory/writeback) and to the forwarding muxes (aluout).

Parameters:
WIDTH, 16, operand width; results are 2*WIDTH.
ITER, 16, iterations for MUL/DIV; must equal WIDTH.

Ports:
clk  in  1  clock
rst  in  1  reset
halt_sys  in  1  global freeze from main control
in_valid  in  1  stage-one bundle holds a real instruction (0 = bubble)
in_a  in  WIDTH  ALU operand a
in_b  in  WIDTH  ALU operand b
in_ctrl  in  4  ALU control: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRL, 6 MUL, 7 DIV, others NOP
in_reg_wr  in  1  register write request
in_R0_en  in  1  upper result half writes R0
in_memc  in  2  memory control, passed through
in_instr  in  16  instruction tag, passed through
stall  out  1  stage one and PC must hold
out_valid  out  1  result bundle valid
out_result  out  2*WIDTH  [15:0] = primary result; [31:16] = R0 part (MUL high product, DIV remainder, else 0)
out_reg_wr  out  1  qualified register write
out_R0_en  out  1  qualified R0 write
out_memc  out  2  passed-through memory control
out_instr  out  16  passed-through tag
div0  out  1  one-cycle flag: DIV by zero
overflow  out  1  one-cycle flag: signed ADD/SUB overflow

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk. On reset:
  - state = IDLE, iteration counter = 0.
  - All outputs = 0, including stall.
- FSM states: IDLE, MUL_RUN, DIV_RUN.
- IDLE with in_valid=0:
  - Next edge: out_valid=0, out_reg_wr=0, out_R0_en=0, out_memc=0, div0=0, overflow=0.
  - out_result and out_instr hold their previous values.
- IDLE, single-cycle op: result is registered at the next edge (latency 1).
  - ADD/SUB: 16-bit wrap. overflow=1 when the signed result overflows; out_reg_wr and out_R0_en are then forced to 0.
  - AND/OR: bitwise.
  - SLL/SRL: shift in_a by in_b[3:0]; zero fill.
  - out_result[31:16] = 0 for all single-cycle ops.
- IDLE, NOP code (8-15): out_valid=1, out_reg_wr=0, out_R0_en=0, out_result=0.
- IDLE, MUL: latch operands and pass-through fields, counter=0, go to MUL_RUN.
  - Unsigned shift-add, one multiplier bit per cycle.
- IDLE, DIV with in_b != 0: latch operands, go to DIV_RUN.
  - Unsigned restoring division, one quotient bit per cycle.
- IDLE, DIV with in_b == 0: no FSM entry.
  - Next edge: out_valid=1, out_result = {in_a, 16'hFFFF}, div0=1, out_reg_wr=0, out_R0_en=0.
- stall = 1 exactly while state is MUL_RUN or DIV_RUN (registered state, decoded combinationally).
- While stalled:
  - in_* inputs are ignored.
  - out_valid=0 each cycle.
- RUN states:
  - counter increments each cycle.
  - In the cycle counter == ITER-1, the next edge writes the final result with out_valid=1 and returns to IDLE.
  - stall drops in that same edge.
  - Total latency from the accepting edge to out_valid is ITER+1 = 17 edges.
- Back-to-back: the edge that completes a MUL/DIV does not accept a new instruction. The instruction held by stage one is accepted at the following edge.
- halt_sys=1: no register in the block changes (FSM, counter, datapath, outputs). stall keeps its current value.
- rst asserted mid-MUL/DIV: operation is aborted, all outputs return to reset values immediately, and no result is produced.
- div0 and overflow are single-cycle pulses, coincident with out_valid.

Test Plan:
- Reset, then ADD with in_a=16'h7FFF, in_b=1, in_reg_wr=1 → next edge: out_result=32'h00008000, overflow=1, out_reg_wr=0, out_valid=1.
- SUB with in_a=5, in_b=3 → out_result=32'h00000002, overflow=0, out_reg_wr=1. Next cycle in_valid=0 → out_valid=0, out_reg_wr=0.
- MUL with in_a=16'hFFFF, in_b=16'h0002, in_R0_en=1 → stall=1 for 16 cycles. At edge 17: out_result=32'h0001FFFE, out_valid=1, out_R0_en=1. Stall is low in the cycle after.
- DIV with in_a=100, in_b=7 → 17 edges later out_result={16'd2, 16'd14}. DIV with in_b=0 → next edge div0=1, out_result=32'h0064FFFF, out_reg_wr=0.
- Start MUL, assert halt_sys for 5 cycles at cycle 8 → result is valid at edge 22 and still correct; outputs are frozen during the halt.
- Start DIV, assert rst at cycle 6 → stall=0 and out_valid=0 immediately. A new ADD issued after reset completes in 1 cycle.

Source files
------------

// File: rtl/stage_two_execute.sv
// Execute stage: single-cycle ALU ops plus iterative 16-step unsigned MUL/DIV.
// A multi-cycle op stalls stage one and the PC until its result is registered.
module stage_two_execute #(
    parameter int WIDTH = 16,
    parameter int ITER  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 halt_sys,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [3:0]           in_ctrl,
    input  logic                 in_reg_wr,
    input  logic                 in_R0_en,
    input  logic [1:0]           in_memc,
    input  logic [15:0]          in_instr,
    output logic                 stall,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   out_result,
    output logic                 out_reg_wr,
    output logic                 out_R0_en,
    output logic [1:0]           out_memc,
    output logic [15:0]          out_instr,
    output logic                 div0,
    output logic                 overflow
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_MUL = 4'd6;
    localparam logic [3:0] OP_DIV = 4'd7;

    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        count, count_n;
    logic [WIDTH-1:0]     work_hi, work_hi_n;
    logic [WIDTH-1:0]     work_lo, work_lo_n;
    logic [WIDTH-1:0]     opb, opb_n;
    logic                 hold_reg_wr, hold_reg_wr_n;
    logic                 hold_R0_en, hold_R0_en_n;
    logic [1:0]           hold_memc, hold_memc_n;
    logic [15:0]          hold_instr, hold_instr_n;

    logic                 out_valid_n;
    logic [2*WIDTH-1:0]   out_result_n;
    logic                 out_reg_wr_n;
    logic                 out_R0_en_n;
    logic [1:0]           out_memc_n;
    logic [15:0]          out_instr_n;
    logic                 div0_n;
    logic                 overflow_n;

    logic [WIDTH-1:0]     alu_res;
    logic                 alu_ovf;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH-1:0]     mul_hi_next;
    logic [WIDTH-1:0]     mul_lo_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_trial;
    logic                 div_ok;
    logic [WIDTH-1:0]     div_hi_next;
    logic [WIDTH-1:0]     div_lo_next;

    assign stall = (state != IDLE);

    // Single-cycle ALU; overflow is the signed two's-complement overflow of ADD/SUB.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (in_ctrl)
            OP_ADD: begin
                alu_res = in_a + in_b;
                alu_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = in_a - in_b;
                alu_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_AND: alu_res = in_a & in_b;
            OP_OR:  alu_res = in_a | in_b;
            OP_SLL: alu_res = in_a << in_b[3:0];
            OP_SRL: alu_res = in_a >> in_b[3:0];
            default: alu_res = '0;
        endcase
    end

    // MUL step: {hi,lo} shifts right, adding the multiplicand into hi when lo[0] is set.
    // DIV step: remainder in hi, dividend shifts out of lo while quotient bits shift in.
    always_comb begin
        mul_sum     = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        mul_hi_next = mul_sum[WIDTH:1];
        mul_lo_next = {mul_sum[0], work_lo[WIDTH-1:1]};

        div_shift   = {work_hi, work_lo[WIDTH-1]};
        div_trial   = div_shift - {1'b0, opb};
        div_ok      = ~div_trial[WIDTH];
        div_hi_next = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_lo_next = {work_lo[WIDTH-2:0], div_ok};
    end

    always_comb begin
        state_n       = state;
        count_n       = count;
        work_hi_n     = work_hi;
        work_lo_n     = work_lo;
        opb_n         = opb;
        hold_reg_wr_n = hold_reg_wr;
        hold_R0_en_n  = hold_R0_en;
        hold_memc_n   = hold_memc;
        hold_instr_n  = hold_instr;
        out_valid_n   = 1'b0;
        out_result_n  = out_result;
        out_reg_wr_n  = 1'b0;
        out_R0_en_n   = 1'b0;
        out_memc_n    = 2'b00;
        out_instr_n   = out_instr;
        div0_n        = 1'b0;
        overflow_n    = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    case (in_ctrl)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRL: begin
                            out_valid_n  = 1'b1;
                            out_result_n = {{WIDTH{1'b0}}, alu_res};
                            overflow_n   = alu_ovf;
                            out_reg_wr_n = in_reg_wr & ~alu_ovf;
                            out_R0_en_n  = in_R0_en & ~alu_ovf;
                            out_memc_n   = in_memc;
                            out_instr_n  = in_instr;
                        end
                        OP_MUL, OP_DIV: begin
                            if (in_ctrl == OP_DIV && in_b == '0) begin
                                out_valid_n  = 1'b1;
                                out_result_n = {in_a, {WIDTH{1'b1}}};
                                div0_n       = 1'b1;
                                out_memc_n   = in_memc;
                                out_instr_n  = in_instr;
                            end else begin
                                state_n       = (in_ctrl == OP_MUL) ? MUL_RUN : DIV_RUN;
                                count_n       = '0;
                                work_hi_n     = '0;
                                work_lo_n     = in_a;
                                opb_n         = in_b;
                                hold_reg_wr_n = in_reg_wr;
                                hold_R0_en_n  = in_R0_en;
                                hold_memc_n   = in_memc;
                                hold_instr_n  = in_instr;
                            end
                        end
                        default: begin
                            out_valid_n  = 1'b1;
                            out_result_n = '0;
                            out_memc_n   = in_memc;
                            out_instr_n  = in_instr;
                        end
                    endcase
                end
            end
            MUL_RUN, DIV_RUN: begin
                count_n   = count + 1'b1;
                work_hi_n = (state == MUL_RUN) ? mul_hi_next : div_hi_next;
                work_lo_n = (state == MUL_RUN) ? mul_lo_next : div_lo_next;
                if (count == LAST) begin
                    state_n      = IDLE;
                    count_n      = '0;
                    out_valid_n  = 1'b1;
                    out_result_n = {work_hi_n, work_lo_n};
                    out_reg_wr_n = hold_reg_wr;
                    out_R0_en_n  = hold_R0_en;
                    out_memc_n   = hold_memc;
                    out_instr_n  = hold_instr;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // halt_sys freezes every register, including the one-cycle flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            work_hi     <= '0;
            work_lo     <= '0;
            opb         <= '0;
            hold_reg_wr <= 1'b0;
            hold_R0_en  <= 1'b0;
            hold_memc   <= 2'b00;
            hold_instr  <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_reg_wr  <= 1'b0;
            out_R0_en   <= 1'b0;
            out_memc    <= 2'b00;
            out_instr   <= '0;
            div0        <= 1'b0;
            overflow    <= 1'b0;
        end else if (!halt_sys) begin
            state       <= state_n;
            count       <= count_n;
            work_hi     <= work_hi_n;
            work_lo     <= work_lo_n;
            opb         <= opb_n;
            hold_reg_wr <= hold_reg_wr_n;
            hold_R0_en  <= hold_R0_en_n;
            hold_memc   <= hold_memc_n;
            hold_instr  <= hold_instr_n;
            out_valid   <= out_valid_n;
            out_result  <= out_result_n;
            out_reg_wr  <= out_reg_wr_n;
            out_R0_en   <= out_R0_en_n;
            out_memc    <= out_memc_n;
            out_instr   <= out_instr_n;
            div0        <= div0_n;
            overflow    <= overflow_n;
        end
    end

endmodule

// File: tb/tb_stage_two_execute.sv
// Directed bench for stage_two_execute: ALU ops, MUL/DIV latency and stall,
// divide by zero, halt freeze and asynchronous reset abort.
module tb_stage_two_execute;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt_sys;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [3:0]  in_ctrl;
    logic        in_reg_wr;
    logic        in_R0_en;
    logic [1:0]  in_memc;
    logic [15:0] in_instr;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_result;
    logic        out_reg_wr;
    logic        out_R0_en;
    logic [1:0]  out_memc;
    logic [15:0] out_instr;
    logic        div0;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    stage_two_execute #(.WIDTH(16), .ITER(16)) dut (
        .clk(clk), .rst(rst), .halt_sys(halt_sys), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl), .in_reg_wr(in_reg_wr),
        .in_R0_en(in_R0_en), .in_memc(in_memc), .in_instr(in_instr),
        .stall(stall), .out_valid(out_valid), .out_result(out_result),
        .out_reg_wr(out_reg_wr), .out_R0_en(out_R0_en), .out_memc(out_memc),
        .out_instr(out_instr), .div0(div0), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input logic [3:0] ctrl, input logic [15:0] a,
                                  input logic [15:0] b, input logic wr, input logic r0,
                                  input logic [1:0] memc, input logic [15:0] instr);
        in_valid = v; in_ctrl = ctrl; in_a = a; in_b = b;
        in_reg_wr = wr; in_R0_en = r0; in_memc = memc; in_instr = instr;
    endtask

    task automatic test_reset();
        rst = 1'b1; halt_sys = 1'b0;
        apply_stimulus(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 2'b00, 16'h0);
        step(); step();
        checks++; if ({stall, out_valid, out_reg_wr, out_R0_en, div0, overflow} !== 6'b0) begin
            errors++; $display("[TB] FAIL reset_flags: got %b expected 000000", {stall, out_valid, out_reg_wr, out_R0_en, div0, overflow}); end
        checks++; if (out_result !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_result: got %h expected 00000000", out_result); end
        checks++; if ({out_memc, out_instr} !== 18'h0) begin
            errors++; $display("[TB] FAIL reset_passthru: got %h expected 0", {out_memc, out_instr}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_add_sub();
        apply_stimulus(1'b1, 4'd0, 16'h7FFF, 16'h0001, 1'b1, 1'b1, 2'b10, 16'hABCD);
        step();
        checks++; if (out_result !== 32'h00008000) begin
            errors++; $display("[TB] FAIL add_ovf_result: got %h expected 00008000", out_result); end
        checks++; if ({out_valid, overflow, out_reg_wr, out_R0_en} !== 4'b1100) begin
            errors++; $display("[TB] FAIL add_ovf_flags: got %b expected 1100", {out_valid, overflow, out_reg_wr, out_R0_en}); end
        apply_stimulus(1'b1, 4'd1, 16'd5, 16'd3, 1'b1, 1'b0, 2'b01, 16'h1111);
        step();
        checks++; if (out_result !== 32'h00000002) begin
            errors++; $display("[TB] FAIL sub_result: got %h expected 00000002", out_result); end
        checks++; if ({out_valid, overflow, out_reg_wr, out_memc, out_instr} !== {3'b101, 2'b01, 16'h1111}) begin
            errors++; $display("[TB] FAIL sub_fields: got %b %b %b %b %h", out_valid, overflow, out_reg_wr, out_memc, out_instr); end
        apply_stimulus(1'b0, 4'd0, 16'h0, 16'h0, 1'b1, 1'b1, 2'b11, 16'h2222);
        step();
        checks++; if ({out_valid, out_reg_wr, out_R0_en, out_memc, overflow, div0} !== 7'b0) begin
            errors++; $display("[TB] FAIL bubble_flags: got %b expected 0000000", {out_valid, out_reg_wr, out_R0_en, out_memc, overflow, div0}); end
        checks++; if ({out_result, out_instr} !== {32'h00000002, 16'h1111}) begin
            errors++; $display("[TB] FAIL bubble_hold: got %h %h expected 00000002 1111", out_result, out_instr); end
    endtask

    task automatic test_logic_shift();
        logic [3:0]  ctrl [7] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd0, 4'd9};
        logic [15:0] a    [7] = '{16'hF0F0, 16'hF0F0, 16'h0001, 16'h8000, 16'h8000, 16'hFFFF, 16'h1234};
        logic [15:0] b    [7] = '{16'h3C3C, 16'h3C3C, 16'h0013, 16'h000F, 16'h0001, 16'h0001, 16'h5678};
        logic [31:0] res  [7] = '{32'h3030, 32'hFCFC, 32'h0008, 32'h0001, 32'h7FFF, 32'h0000, 32'h0000};
        logic        ovf  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        wr   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(1'b1, ctrl[i], a[i], b[i], 1'b1, 1'b0, 2'b00, 16'h0);
            step();
            checks++; if ({out_valid, out_result, overflow, out_reg_wr} !== {1'b1, res[i], ovf[i], wr[i]}) begin
                errors++; $display("[TB] FAIL alu_vec%0d: got v=%b r=%h o=%b w=%b expected v=1 r=%h o=%b w=%b",
                                   i, out_valid, out_result, overflow, out_reg_wr, res[i], ovf[i], wr[i]); end
        end
        apply_stimulus(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 2'b00, 16'h0);
        step();
    endtask

    // Accepting edge counts as edge 1; the result lands on edge 17 and the
    // ADD held on the inputs meanwhile is accepted on edge 18.
    task automatic test_mul_back_to_back();
        logic [15:0] a   [2] = '{16'hFFFF, 16'hFFFF};
        logic [15:0] b   [2] = '{16'h0002, 16'hFFFF};
        logic [31:0] res [2] = '{32'h0001FFFE, 32'hFFFE0001};
        int bad;
        for (int v = 0; v < 2; v++) begin
            apply_stimulus(1'b1, 4'd6, a[v], b[v], 1'b1, 1'b1, 2'b10, 16'hC0DE);
            step();
            apply_stimulus(1'b1, 4'd0, 16'd3, 16'd4, 1'b1, 1'b0, 2'b00, 16'h0AD0);
            bad = 0;
            for (int e = 1; e <= 16; e++) begin
                if (e > 1) step();
                if (stall !== 1'b1 || out_valid !== 1'b0) bad++;
            end
            checks++; if (bad != 0) begin
                errors++; $display("[TB] FAIL mul%0d_stall: got %0d bad cycles expected 0", v, bad); end
            step();
            checks++; if ({out_valid, out_result, out_R0_en, out_reg_wr, stall} !== {1'b1, res[v], 3'b110}) begin
                errors++; $display("[TB] FAIL mul%0d_done: got v=%b r=%h r0=%b w=%b s=%b expected v=1 r=%h r0=1 w=1 s=0",
                                   v, out_valid, out_result, out_R0_en, out_reg_wr, stall, res[v]); end
            checks++; if ({out_memc, out_instr} !== {2'b10, 16'hC0DE}) begin
                errors++; $display("[TB] FAIL mul%0d_passthru: got %b %h expected 10 c0de", v, out_memc, out_instr); end
            step();
            checks++; if ({out_valid, out_result, stall, out_instr} !== {1'b1, 32'h7, 1'b0, 16'h0AD0}) begin
                errors++; $display("[TB] FAIL mul%0d_next_add: got v=%b r=%h s=%b i=%h expected v=1 r=00000007 s=0 i=0ad0",
                                   v, out_valid, out_result, stall, out_instr); end
        end
        apply_stimulus(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 2'b00, 16'h0);
        step();
    endtask

    task automatic test_div();
        logic [15:0] a   [3] = '{16'd100, 16'hFFFF, 16'd7};
        logic [15:0] b   [3] = '{16'd7, 16'h0001, 16'd100};
        logic [31:0] res [3] = '{32'h0002000E, 32'h0000FFFF, 32'h00070000};
        int bad;
        for (int v = 0; v < 3; v++) begin
            apply_stimulus(1'b1, 4'd7, a[v], b[v], 1'b1, 1'b1, 2'b00, 16'h0D1F);
            step();
            apply_stimulus(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 2'b00, 16'h0);
            bad = 0;
            for (int e = 1; e <= 16; e++) begin
                if (e > 1) step();
                if (stall !== 1'b1 || out_valid !== 1'b0) bad++;
            end
            checks++; if (bad != 0) begin
                errors++; $display("[TB] FAIL div%0d_stall: got %0d bad cycles expected 0", v, bad); end
            step();
            checks++; if ({out_valid, out_result, div0, stall} !== {1'b1, res[v], 2'b00}) begin
                errors++; $display("[TB] FAIL div%0d_done: got v=%b r=%h d0=%b s=%b expected v=1 r=%h d0=0 s=0",
                                   v, out_valid, out_result, div0, stall, res[v]); end
        end
        apply_stimulus(1'b1, 4'd7, 16'd100, 16'd0, 1'b1, 1'b1, 2'b00, 16'h0);
        step();
        apply_stimulus(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 2'b00, 16'h0);
        checks++; if ({out_valid, out_result, div0, out_reg_wr, out_R0_en, stall} !== {1'b1, 32'h0064FFFF, 4'b1000}) begin
            errors++; $display("[TB] FAIL div0: got v=%b r=%h d0=%b w=%b r0=%b s=%b expected v=1 r=0064ffff d0=1 w=0 r0=0 s=0",
                               out_valid, out_result, div0, out_reg_wr, out_R0_en, stall); end
        step();
        checks++; if ({div0, out_valid} !== 2'b00) begin
            errors++; $display("[TB] FAIL div0_pulse: got %b expected 00", {div0, out_valid}); end
    endtask

    task automatic test_halt();
        int bad;
        apply_stimulus(1'b1, 4'd0, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 2'b00, 16'h0);
        step();
        apply_stimulus(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 2'b00, 16'h0);
        halt_sys = 1'b1;
        step(); step();
        checks++; if ({overflow, out_valid, out_result} !== {2'b11, 32'h00008000}) begin
            errors++; $display("[TB] FAIL halt_freeze_flags: got o=%b v=%b r=%h expected o=1 v=1 r=00008000", overflow, out_valid, out_result); end
        halt_sys = 1'b0;
        step();
        checks++; if ({overflow, out_valid} !== 2'b00) begin
            errors++; $display("[TB] FAIL halt_release: got %b expected 00", {overflow, out_valid}); end

        apply_stimulus(1'b1, 4'd6, 16'h1234, 16'h0010, 1'b1, 1'b0, 2'b00, 16'h0);
        step();
        apply_stimulus(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 2'b00, 16'h0);
        for (int e = 2; e <= 8; e++) step();
        halt_sys = 1'b1;
        bad = 0;
        for (int e = 9; e <= 13; e++) begin
            step();
            if (stall !== 1'b1 || out_valid !== 1'b0) bad++;
        end
        halt_sys = 1'b0;
        checks++; if (bad != 0) begin
            errors++; $display("[TB] FAIL halt_mul_frozen: got %0d bad cycles expected 0", bad); end
        for (int e = 14; e <= 21; e++) step();
        checks++; if ({out_valid, stall} !== 2'b01) begin
            errors++; $display("[TB] FAIL halt_mul_edge21: got v=%b s=%b expected v=0 s=1", out_valid, stall); end
        step();
        checks++; if ({out_valid, out_result, stall} !== {1'b1, 32'h00012340, 1'b0}) begin
            errors++; $display("[TB] FAIL halt_mul_edge22: got v=%b r=%h s=%b expected v=1 r=00012340 s=0", out_valid, out_result, stall); end
    endtask

    task automatic test_reset_abort();
        int seen;
        apply_stimulus(1'b1, 4'd7, 16'd100, 16'd7, 1'b1, 1'b1, 2'b00, 16'h0);
        step();
        apply_stimulus(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 2'b00, 16'h0);
        for (int e = 2; e <= 6; e++) step();
        #2 rst = 1'b1;
        #1;
        checks++; if ({stall, out_valid, out_result} !== {2'b00, 32'h0}) begin
            errors++; $display("[TB] FAIL abort_immediate: got s=%b v=%b r=%h expected s=0 v=0 r=00000000", stall, out_valid, out_result); end
        step();
        rst = 1'b0;
        apply_stimulus(1'b1, 4'd0, 16'd2, 16'd3, 1'b1, 1'b0, 2'b00, 16'h0);
        step();
        checks++; if ({out_valid, out_result, stall, out_reg_wr} !== {1'b1, 32'h5, 2'b01}) begin
            errors++; $display("[TB] FAIL abort_add: got v=%b r=%h s=%b w=%b expected v=1 r=00000005 s=0 w=1", out_valid, out_result, stall, out_reg_wr); end
        apply_stimulus(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 2'b00, 16'h0);
        seen = 0;
        for (int e = 0; e < 20; e++) begin
            step();
            if (out_valid !== 1'b0 || stall !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin
            errors++; $display("[TB] FAIL abort_no_result: got %0d active cycles expected 0", seen); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_logic_shift();
        test_mul_back_to_back();
        test_div();
        test_halt();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
